// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: owns the oscillator enable, prescales ro_clk in its own
// domain, synchronises the prescaled MSB into clk and counts its rising edges over a gate window.
`timescale 1ns/1ps
module ro_freq_meter #(
  parameter int unsigned PRE_W       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned GATE_W      = 16,
  parameter int unsigned WARM_CYCLES = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              ro_clk,
  output logic              ro_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  localparam int unsigned WARM_W = $clog2(WARM_CYCLES + 1);
  localparam int unsigned TMR_W  = (GATE_W > WARM_W) ? GATE_W : WARM_W;

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_GATE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_en_sync;
  logic [PRE_W-1:0]    r_presc;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                r_sync_q;
  logic                w_edge;
  logic [TMR_W-1:0]    r_tmr;
  logic                w_tmr_zero;
  logic [GATE_W-1:0]   r_gate_m1;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic                r_ovf_int;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_ovf_nxt;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;

  // Oscillator domain: enable is resynchronised; prescaler held at 0 while disabled.
  always_ff @(posedge ro_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_sync <= '0;
      r_presc   <= '0;
    end else begin
      r_en_sync <= {r_en_sync[0], ro_en};
      if (!r_en_sync[1]) r_presc <= '0;
      else               r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], r_presc[PRE_W-1]};
      r_sync_q <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_sync_q;
  assign w_tmr_zero = (r_tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_WARM;
      S_WARM: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_tmr_zero) w_state_nxt = S_GATE;
      end
      S_GATE: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_tmr_zero) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ro_en = (r_state == S_WARM) || (r_state == S_GATE);
    busy  = (r_state != S_IDLE);
    done  = (r_state == S_DONE);
  end

  // Saturating edge count including an edge seen in the final gate cycle.
  always_comb begin
    w_cnt_nxt = r_edge_cnt;
    w_ovf_nxt = r_ovf_int;
    if ((r_state == S_GATE) && w_edge) begin
      if (r_edge_cnt == '1) w_ovf_nxt = 1'b1;
      else                  w_cnt_nxt = r_edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr      <= '0;
      r_gate_m1  <= '0;
      r_edge_cnt <= '0;
      r_ovf_int  <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tmr      <= TMR_W'(WARM_CYCLES - 1);
            r_gate_m1  <= (gate_cycles == '0) ? '0 : gate_cycles - 1'b1;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
          end
        end
        S_WARM: begin
          if (w_tmr_zero) r_tmr <= TMR_W'(r_gate_m1);
          else            r_tmr <= r_tmr - 1'b1;
        end
        S_GATE: begin
          r_edge_cnt <= w_cnt_nxt;
          r_ovf_int  <= w_ovf_nxt;
          if (!w_tmr_zero) begin
            r_tmr <= r_tmr - 1'b1;
          end else if (!abort) begin
            r_count <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Measures the frequency of the on-chip ring oscillator and owns its enable. The block sits directly downstream of the ring oscillator: it drives the oscillator's enable and consumes its output. It divides the raw oscillator output with a prescaler running in the oscillator domain, then synchronises the prescaled signal into the system clock domain. It counts prescaled rising edges over a programmable gate window and reports a saturating count with a done pulse. Software derives oscillator frequency as count × 2^PRE_W / (gate_cycles × T_clk).

## Interface
- PRE_W, 4: prescaler width. The oscillator output is divided by 2^PRE_W.
- CNT_W, 16: result counter width.
- GATE_W, 16: gate-length field width.
- WARM_CYCLES, 32: clk cycles the oscillator runs before counting starts (settling).
- SYNC_STAGES, 2: synchroniser depth for the prescaled signal. Minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low. Resets every flop in both domains.
- start  in  1  one-cycle measurement request. Accepted only in IDLE.
- abort  in  1  cancels a measurement in progress.
- gate_cycles  in  GATE_W  gate window length in clk cycles. Sampled when start is accepted. Value 0 is treated as 1.
- ro_clk  in  1  ring oscillator output.
- ro_en  out  1  ring oscillator enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when count is updated.
- count  out  CNT_W  prescaled edge count of the last completed measurement.
- ovf  out  1  the last measurement saturated.

## Operation
- Prescaler: a PRE_W-bit up-counter clocked by ro_clk.
  - Async-reset by rst_n.
  - Held at 0 while ro_en is low. The enable is resynchronised into the ro_clk domain with 2 flops, or the prescaler is reset by !ro_en.
  - The prescaler MSB feeds a SYNC_STAGES flop chain on clk. A rising-edge detector follows the chain.
- States:
  - IDLE: ro_en=0, busy=0.
  - WARM: ro_en=1. Counts WARM_CYCLES clk cycles. Edges are ignored.
  - GATE: ro_en=1. Counts max(gate_cycles,1) clk cycles. The edge counter increments on each detected edge.
  - DONE: one cycle. ro_en=0, done=1, count and ovf updated.
- Transitions:
  - IDLE → WARM on start. gate_cycles is latched and the edge counter is cleared.
  - WARM → GATE when the warm timer expires.
  - GATE → DONE when the gate timer expires.
  - DONE → IDLE unconditionally.
  - abort in WARM or GATE → IDLE next cycle. ro_en drops, there is no done pulse, and count/ovf keep their previous values.
- Arithmetic: the edge counter saturates at 2^CNT_W−1. A further edge sets the internal overflow flag. The internal flag is copied to ovf in DONE.
- Simultaneous events:
  - start outside IDLE is ignored.
  - abort in IDLE or DONE is ignored. DONE completes normally.
  - start and abort together in IDLE: start wins, and abort is ignored.
- Accuracy: the count is ±1 of the ideal due to the synchroniser. Valid only if the prescaled frequency is below f_clk/2.

## Timing
- Reset values: ro_en=0, busy=0, done=0, count=0, ovf=0, state IDLE, prescaler 0.
- start sampled high at edge T:
  - busy=1 and ro_en=1 from T+1.
  - GATE entered at T+1+WARM_CYCLES.
  - DONE occupies cycle T+1+WARM_CYCLES+G, with G = max(gate_cycles,1).
- In the DONE cycle: done=1, count/ovf show new values, ro_en=0, busy=1.
- IDLE again one cycle after DONE, with busy=0. The earliest next accepted start is that cycle.
- count/ovf are stable from DONE until the next DONE.
- rst_n asserted mid-measurement: all outputs return to reset values immediately. The oscillator stops.

## Test plan
- Reset check: assert rst_n=0 mid-GATE → ro_en, busy, done, count, ovf all 0 with no clk edge. Deassert → IDLE, start accepted.
- Nominal measurement: clk 10 ns, ro_clk 2 ns, PRE_W=4, WARM_CYCLES=32, gate_cycles=320.
  - count ∈ {99,100,101}.
  - done exactly 1 cycle, at start+1+32+320.
  - ro_en high for exactly 352 cycles.
- Saturation: CNT_W=8, ro_clk 2 ns, gate_cycles=1000 → count=255, ovf=1. A following measurement with gate_cycles=10 → ovf=0, count ∈ {2,3,4}.
- Abort: abort 5 cycles into GATE after a prior result of 100 → ro_en low next cycle, no done, count stays 100, busy=0.
- Ignored start / zero gate:
  - start pulsed during WARM → no effect, single done.
  - gate_cycles=0 → GATE lasts 1 cycle, count ∈ {0,1}.
- Enable hold: in IDLE, toggle ro_clk → prescaler stays 0, no edges counted. The first measurement after 10 idle µs still matches the nominal result.
